// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (core, external) and the memory macro.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wd;
   logic [DW-1:0] cpu_rd;
   logic          cpu_ready;

   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_adr;
   logic [DW-1:0] ext_wd;
   logic [DW-1:0] ext_rd;
   logic          ext_ready;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_we, cpu_adr, cpu_wd,
      output cpu_rd, cpu_ready,
      input  ext_req, ext_we, ext_adr, ext_wd,
      output ext_rd, ext_ready,
      output mem_en, mem_we, mem_adr, mem_wd,
      input  mem_rd
   );

   modport master (
      output cpu_req, cpu_we, cpu_adr, cpu_wd,
      input  cpu_rd, cpu_ready,
      output ext_req, ext_we, ext_adr, ext_wd,
      input  ext_rd, ext_ready,
      input  mem_en, mem_we, mem_adr, mem_wd,
      output mem_rd
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between the core (fixed priority) and one external requester,
// with a starvation bound that forces an external grant after STARVE_MAX consecutive core grants.
//
// state | meaning
// IDLE  | arbitrate; on grant latch owner/we/adr/wd and launch the memory strobe
// ISSUE | mem_en high for one cycle; writes finish, reads start counting latency
// WAIT  | read latency down-counter running, mem_en low
// DONE  | one-cycle ready pulse to the owner only
module mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

   localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t        state;
   owner_t        owner;
   logic [3:0]    starve_cnt;
   logic [3:0]    lat_cnt;
   logic          we_q;
   logic          mem_en_q;
   logic          mem_we_q;
   logic          cpu_ready_q;
   logic          ext_ready_q;
   logic [AW-1:0] adr_q;
   logic [DW-1:0] wd_q;
   logic [DW-1:0] cpu_rd_q;
   logic [DW-1:0] ext_rd_q;

   logic any_req;
   logic grant_ext;
   logic lat_tc;

   assign any_req   = bus.cpu_req | bus.ext_req;
   assign grant_ext = bus.ext_req & (~bus.cpu_req | (starve_cnt == STARVE_LIM));
   assign lat_tc    = (lat_cnt == 4'd0);

   // Latency is counted from the edge that launches mem_en, so the counter is
   // loaded at grant and mem_rd is sampled in the cycle it reaches terminal count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= OWN_CPU;
         starve_cnt  <= 4'd0;
         lat_cnt     <= 4'd0;
         we_q        <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_ready_q <= 1'b0;
         ext_ready_q <= 1'b0;
         adr_q       <= '0;
         wd_q        <= '0;
         cpu_rd_q    <= '0;
         ext_rd_q    <= '0;
      end else begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_ready_q <= 1'b0;
         ext_ready_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.ext_req) starve_cnt <= 4'd0;
               if (any_req) begin
                  owner    <= grant_ext ? OWN_EXT : OWN_CPU;
                  we_q     <= grant_ext ? bus.ext_we  : bus.cpu_we;
                  adr_q    <= grant_ext ? bus.ext_adr : bus.cpu_adr;
                  wd_q     <= grant_ext ? bus.ext_wd  : bus.cpu_wd;
                  mem_en_q <= 1'b1;
                  mem_we_q <= grant_ext ? bus.ext_we  : bus.cpu_we;
                  lat_cnt  <= LAT_LOAD;
                  state    <= ISSUE;
                  if (grant_ext)
                     starve_cnt <= 4'd0;
                  else if (bus.ext_req && starve_cnt != STARVE_LIM)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            ISSUE, WAIT: begin
               if (state == ISSUE && we_q) begin
                  cpu_ready_q <= (owner == OWN_CPU);
                  ext_ready_q <= (owner == OWN_EXT);
                  state       <= DONE;
               end else if (lat_tc) begin
                  if (owner == OWN_CPU) cpu_rd_q <= bus.mem_rd;
                  else                  ext_rd_q <= bus.mem_rd;
                  cpu_ready_q <= (owner == OWN_CPU);
                  ext_ready_q <= (owner == OWN_EXT);
                  state       <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
                  state   <= WAIT;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_en_q & mem_we_q;
   assign bus.mem_adr   = adr_q;
   assign bus.mem_wd    = wd_q;
   assign bus.cpu_rd    = cpu_rd_q;
   assign bus.cpu_ready = cpu_ready_q;
   assign bus.ext_rd    = ext_rd_q;
   assign bus.ext_ready = ext_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=2 and one at MEM_LAT=1, each with a
// memory model that only presents valid read data in the cycle the arbiter should sample it.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(32), .DW(32)) b2 ();
   mem_arbiter_if #(.AW(32), .DW(32)) b1 ();

   mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] adr);
      if (adr == 32'h10) return 32'hDEAD_BEEF;
      return {adr[15:0], ~adr[15:0]};
   endfunction

   // MEM_LAT=2: data valid only in the cycle after the mem_en cycle
   int          cyc     = 0;
   int          en_cyc2 = -100;
   logic [31:0] en_adr2 = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (b2.mem_en) begin
         en_cyc2 <= cyc;
         en_adr2 <= b2.mem_adr;
      end
   end

   assign b2.mem_rd = (cyc == en_cyc2 + 1) ? mem_data(en_adr2) : 32'hBAD0_0002;
   assign b1.mem_rd = b1.mem_en ? mem_data(b1.mem_adr) : 32'hBAD0_0001;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [31:0] grant_adr [6];
   int          n_en;
   int          n_rdy;
   int          n_dual;
   int          cpu_t;
   int          ext_t;
   int          n_late;
   int          rdy_at [4];
   int          n6;

   initial begin
      reset      = 1'b0;
      b2.cpu_req = 1'b0; b2.cpu_we = 1'b0; b2.cpu_adr = '0; b2.cpu_wd = '0;
      b2.ext_req = 1'b0; b2.ext_we = 1'b0; b2.ext_adr = '0; b2.ext_wd = '0;
      b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_adr = '0; b1.cpu_wd = '0;
      b1.ext_req = 1'b0; b1.ext_we = 1'b0; b1.ext_adr = '0; b1.ext_wd = '0;

      // reset state
      @(negedge clk);
      check_eq("rst_mem_en",    b2.mem_en,    0);
      check_eq("rst_mem_we",    b2.mem_we,    0);
      check_eq("rst_cpu_ready", b2.cpu_ready, 0);
      check_eq("rst_ext_ready", b2.ext_ready, 0);
      check_eq("rst_mem_adr",   b2.mem_adr,   0);
      check_eq("rst_mem_wd",    b2.mem_wd,    0);
      check_eq("rst_cpu_rd",    b2.cpu_rd,    0);
      check_eq("rst_ext_rd",    b2.ext_rd,    0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // core read, MEM_LAT=2
      b2.cpu_we = 1'b0; b2.cpu_adr = 32'h10; b2.cpu_req = 1'b1;
      @(negedge clk);
      check_eq("t1_issue_en",  b2.mem_en,    1);
      check_eq("t1_issue_adr", b2.mem_adr,   32'h10);
      check_eq("t1_issue_we",  b2.mem_we,    0);
      check_eq("t1_no_rdy1",   b2.cpu_ready, 0);
      @(negedge clk);
      check_eq("t1_wait_en",   b2.mem_en,    0);
      check_eq("t1_no_rdy2",   b2.cpu_ready, 0);
      @(negedge clk);
      check_eq("t1_cpu_ready", b2.cpu_ready, 1);
      check_eq("t1_cpu_rd",    b2.cpu_rd,    32'hDEAD_BEEF);
      check_eq("t1_ext_ready", b2.ext_ready, 0);
      b2.cpu_req = 1'b0;
      @(negedge clk);
      check_eq("t1_pulse_end", b2.cpu_ready, 0);

      // external write, no core request
      b2.ext_we = 1'b1; b2.ext_adr = 32'h20; b2.ext_wd = 32'h5A5A_5A5A; b2.ext_req = 1'b1;
      @(negedge clk);
      check_eq("t2_en",        b2.mem_en,    1);
      check_eq("t2_we",        b2.mem_we,    1);
      check_eq("t2_adr",       b2.mem_adr,   32'h20);
      check_eq("t2_wd",        b2.mem_wd,    32'h5A5A_5A5A);
      check_eq("t2_no_rdy",    b2.ext_ready, 0);
      @(negedge clk);
      check_eq("t2_ext_ready", b2.ext_ready, 1);
      check_eq("t2_cpu_ready", b2.cpu_ready, 0);
      check_eq("t2_en_low",    b2.mem_en,    0);
      check_eq("t2_we_low",    b2.mem_we,    0);
      check_eq("t2_adr_hold",  b2.mem_adr,   32'h20);
      check_eq("t2_cpu_rd",    b2.cpu_rd,    32'hDEAD_BEEF);
      check_eq("t2_ext_rd",    b2.ext_rd,    0);
      b2.ext_req = 1'b0; b2.ext_we = 1'b0;
      @(negedge clk);
      check_eq("t2_pulse_end", b2.ext_ready, 0);

      // both requests held: starvation bound
      b2.cpu_adr = 32'h100; b2.ext_adr = 32'h200;
      b2.cpu_req = 1'b1;    b2.ext_req = 1'b1;
      n_en = 0; n_rdy = 0; n_dual = 0;
      for (int i = 0; i < 80 && n_rdy < 6; i++) begin
         @(negedge clk);
         if (b2.mem_en && n_en < 6) begin
            grant_adr[n_en] = b2.mem_adr;
            n_en++;
         end
         if (b2.cpu_ready && b2.ext_ready) n_dual++;
         if (b2.ext_ready) check_eq("t3_ext_rd", b2.ext_rd, mem_data(32'h200));
         if (b2.cpu_ready) check_eq("t3_cpu_rd", b2.cpu_rd, mem_data(32'h100));
         if (b2.cpu_ready || b2.ext_ready) n_rdy++;
         if (n_rdy == 6) begin
            b2.cpu_req = 1'b0;
            b2.ext_req = 1'b0;
         end
      end
      check_eq("t3_done",       n_rdy,  6);
      check_eq("t3_dual_ready", n_dual, 0);
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("t3_grant%0d", i), grant_adr[i], (i == 4) ? 32'h200 : 32'h100);
      @(negedge clk);
      @(negedge clk);

      // simultaneous first request with starve counter clear
      b2.cpu_adr = 32'h30; b2.ext_adr = 32'h40;
      b2.cpu_req = 1'b1;   b2.ext_req = 1'b1;
      cpu_t = -1; ext_t = -1;
      for (int i = 1; i <= 40 && ext_t < 0; i++) begin
         @(negedge clk);
         if (b2.cpu_ready) begin
            cpu_t = i;
            check_eq("t4_cpu_rd", b2.cpu_rd, mem_data(32'h30));
            b2.cpu_req = 1'b0;
         end
         if (b2.ext_ready) begin
            ext_t = i;
            check_eq("t4_ext_rd", b2.ext_rd, mem_data(32'h40));
            b2.ext_req = 1'b0;
         end
      end
      check_eq("t4_cpu_time", cpu_t, 3);
      check_eq("t4_ext_time", ext_t, 7);
      @(negedge clk);

      // reset during WAIT of a core read
      b2.cpu_adr = 32'h50; b2.cpu_req = 1'b1;
      @(negedge clk);
      check_eq("t5_issue_en", b2.mem_en, 1);
      @(negedge clk);
      check_eq("t5_wait_en",  b2.mem_en, 0);
      reset = 1'b0;
      #1;
      check_eq("t5_rst_en",        b2.mem_en,    0);
      check_eq("t5_rst_cpu_ready", b2.cpu_ready, 0);
      check_eq("t5_rst_ext_ready", b2.ext_ready, 0);
      check_eq("t5_rst_cpu_rd",    b2.cpu_rd,    0);
      check_eq("t5_rst_adr",       b2.mem_adr,   0);
      b2.cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      n_late = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (b2.cpu_ready || b2.ext_ready || b2.mem_en) n_late++;
      end
      check_eq("t5_no_late_ready", n_late, 0);
      b2.cpu_adr = 32'h60; b2.cpu_req = 1'b1;
      @(negedge clk);
      check_eq("t5_re_en",  b2.mem_en,  1);
      check_eq("t5_re_adr", b2.mem_adr, 32'h60);
      @(negedge clk);
      check_eq("t5_re_no_rdy", b2.cpu_ready, 0);
      @(negedge clk);
      check_eq("t5_re_ready", b2.cpu_ready, 1);
      check_eq("t5_re_rd",    b2.cpu_rd,    mem_data(32'h60));
      b2.cpu_req = 1'b0;
      @(negedge clk);

      // MEM_LAT=1, back-to-back core reads with req held
      b1.cpu_we = 1'b0; b1.cpu_adr = 32'h70; b1.cpu_req = 1'b1;
      n6 = 0;
      for (int i = 1; i <= 40 && n6 < 4; i++) begin
         @(negedge clk);
         if (b1.cpu_ready) begin
            check_eq($sformatf("t6_rd%0d", n6), b1.cpu_rd, mem_data(32'h70 + 32'(n6 * 4)));
            rdy_at[n6] = i;
            n6++;
            if (n6 < 4) b1.cpu_adr = 32'h70 + 32'(n6 * 4);
            else        b1.cpu_req = 1'b0;
         end
      end
      check_eq("t6_count", n6, 4);
      for (int i = 0; i < 4; i++)
         check_eq($sformatf("t6_time%0d", i), rdy_at[i], 2 + 3 * i);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
